// File: rtl/schedule_sequencer.sv
// schedule_sequencer: step sequencer for the shared mult/div datapath.
// Programmable modulus, single/continuous passes, stop, pipeline drain.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   en              global stall (low freezes the sequence)
//   clr             synchronous abort to IDLE
//   start/mode/limit  launch a sequence (limit 0 or >MAX selects MAX)
//   stop            end continuous operation at the next wrap
//   count           current step index
//   pass_cnt        passes completed since start
//   busy/last/wrap/done  status and one-clock event pulses
module schedule_sequencer #(
    parameter int WIDTH = 8,
    parameter int MAX   = 211,
    parameter int DRAIN = 4,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic [PW-1:0]    pass_cnt,
    output logic             busy,
    output logic             last,
    output logic             wrap,
    output logic             done
);

    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [DW-1:0] DLAST = DW'((DRAIN > 0) ? DRAIN - 1 : 0);
    localparam logic [WIDTH-1:0] LMAX = WIDTH'(MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DRN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] lim_in;
    logic             mode_r;
    logic             stop_pend;
    logic [DW-1:0]    drain_cnt;
    logic             at_end;
    logic             end_seq;
    logic             drain_end;
    logic             wrap_nx;
    logic             done_nx;

    assign lim_in    = (limit == '0 || limit > LMAX) ? LMAX : limit;
    assign at_end    = (count == lim - 1'b1);
    // A stop raised in the wrap cycle itself still ends this pass.
    assign end_seq   = !mode_r || stop_pend || stop;
    assign drain_end = (drain_cnt == DLAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) state_nx = RUN;
                RUN: begin
                    if (en && at_end && end_seq)
                        state_nx = (DRAIN == 0) ? IDLE : DRN;
                end
                DRN: if (en && drain_end) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        last    = (state == RUN) && at_end;
        wrap_nx = !clr && (state == RUN) && en && at_end;
        done_nx = 1'b0;
        if (!clr) begin
            if (state == RUN && en && at_end && end_seq && DRAIN == 0)
                done_nx = 1'b1;
            if (state == DRN && en && drain_end)
                done_nx = 1'b1;
        end
    end

    // Datapath and registered status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            pass_cnt  <= '0;
            lim       <= LMAX;
            mode_r    <= 1'b0;
            stop_pend <= 1'b0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
        end else begin
            wrap <= wrap_nx;
            done <= done_nx;
            busy <= (state_nx != IDLE);
            if (clr) begin
                // pass_cnt is kept so an aborted run can be inspected
                count     <= '0;
                drain_cnt <= '0;
                stop_pend <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        count <= '0;
                        if (start) begin
                            lim       <= lim_in;
                            mode_r    <= mode;
                            pass_cnt  <= '0;
                            stop_pend <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (stop) stop_pend <= 1'b1;
                        if (en) begin
                            if (at_end) begin
                                count    <= '0;
                                pass_cnt <= pass_cnt + 1'b1;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                    DRN: begin
                        if (en)
                            drain_cnt <= drain_end ? '0 : drain_cnt + 1'b1;
                    end
                    default: count <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_schedule_sequencer.sv
// tb_schedule_sequencer: scoreboard bench for schedule_sequencer.
// A cycle model pushes expected outputs; they are popped after each edge.
module tb_schedule_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clr, start, mode, stop;
    logic [7:0] limit;
    logic [7:0] count;
    logic [3:0] pass_cnt;
    logic       busy, last, wrap, done;

    schedule_sequencer dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .start(start), .mode(mode), .limit(limit), .stop(stop),
        .count(count), .pass_cnt(pass_cnt), .busy(busy),
        .last(last), .wrap(wrap), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cnt;
        logic [3:0] pass;
        logic       busy;
        logic       wrap;
        logic       done;
        logic       last;
    } exp_t;

    exp_t sb[$];

    int nvec = 0;
    int nerr = 0;

    // reference model state
    int m_st, m_cnt, m_pass, m_lim, m_mode, m_sp, m_dc;
    int m_busy, m_wrap, m_done;

    int edge_n, n_wrap, n_done, wrap_edge, done_edge, wrap_hi;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_pass = 0; m_lim = 211; m_mode = 0;
        m_sp = 0; m_dc = 0; m_busy = 0; m_wrap = 0; m_done = 0;
    endtask

    // Expected behaviour of one rising edge given current inputs.
    task automatic model_edge();
        int fin;
        m_wrap = 0;
        m_done = 0;
        if (clr) begin
            m_st = 0; m_cnt = 0; m_dc = 0; m_sp = 0;
        end else if (m_st == 0) begin
            m_cnt = 0;
            if (start) begin
                m_st   = 1;
                m_lim  = (limit == 0 || limit > 211) ? 211 : int'(limit);
                m_mode = int'(mode);
                m_pass = 0;
                m_sp   = 0;
            end
        end else if (m_st == 1) begin
            fin = (m_mode == 0 || m_sp != 0 || stop) ? 1 : 0;
            if (stop) m_sp = 1;
            if (en) begin
                if (m_cnt == m_lim - 1) begin
                    m_cnt  = 0;
                    m_pass = (m_pass + 1) % 16;
                    m_wrap = 1;
                    if (fin != 0) m_st = 2;
                end else begin
                    m_cnt++;
                end
            end
        end else begin
            if (en) begin
                if (m_dc == 3) begin
                    m_st = 0; m_done = 1; m_dc = 0;
                end else begin
                    m_dc++;
                end
            end
        end
        m_busy = (m_st != 0) ? 1 : 0;
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        e.cnt  = 8'(m_cnt);
        e.pass = 4'(m_pass);
        e.busy = m_busy[0];
        e.wrap = m_wrap[0];
        e.done = m_done[0];
        e.last = (m_st == 1 && m_cnt == m_lim - 1);
        sb.push_back(e);
        @(posedge clk);
        edge_n++;
        #1;
        e = sb.pop_front();
        chk("count", 32'(count), 32'(e.cnt));
        chk("pass_cnt", 32'(pass_cnt), 32'(e.pass));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("wrap", 32'(wrap), 32'(e.wrap));
        chk("done", 32'(done), 32'(e.done));
        chk("last", 32'(last), 32'(e.last));
        if (wrap) begin
            n_wrap++; wrap_hi++; wrap_edge = edge_n;
        end
        if (done) begin
            n_done++; done_edge = edge_n;
        end
    endtask

    task automatic new_scn();
        edge_n = -1; n_wrap = 0; n_done = 0;
        wrap_edge = -1; done_edge = -1; wrap_hi = 0;
    endtask

    task automatic idle_in();
        en = 1'b1; clr = 1'b0; start = 1'b0;
        mode = 1'b0; stop = 1'b0; limit = 8'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        model_reset();
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single pass at full modulus
        new_scn();
        start = 1'b1; limit = 8'd0;
        step();
        start = 1'b0;
        for (int i = 0; i < 220; i++) step();
        chk("sp_wrap_edge", 32'(wrap_edge), 32'd211);
        chk("sp_done_edge", 32'(done_edge), 32'd215);
        chk("sp_nwrap", 32'(n_wrap), 32'd1);
        chk("sp_ndone", 32'(n_done), 32'd1);
        chk("sp_pass", 32'(pass_cnt), 32'd1);

        // Continuous, stop in the third pass
        new_scn();
        start = 1'b1; mode = 1'b1; limit = 8'd5;
        step();
        start = 1'b0; mode = 1'b0;
        for (int i = 0; i < 40; i++) begin
            stop = (m_st == 1 && m_cnt == 2 && m_pass == 2);
            step();
        end
        stop = 1'b0;
        chk("ct_nwrap", 32'(n_wrap), 32'd3);
        chk("ct_ndone", 32'(n_done), 32'd1);
        chk("ct_pass", 32'(pass_cnt), 32'd3);
        chk("ct_count", 32'(count), 32'd0);

        // Stall: en alternates, start taken with en low
        new_scn();
        start = 1'b1; limit = 8'd10; en = 1'b0;
        step();
        start = 1'b0;
        for (int k = 1; k < 40; k++) begin
            en = k[0];
            step();
        end
        en = 1'b1;
        chk("st_wrap_edge", 32'(wrap_edge), 32'd19);
        chk("st_drain_len", 32'(done_edge - wrap_edge), 32'd8);
        chk("st_wrap_w", 32'(wrap_hi), 32'd1);
        chk("st_ndone", 32'(n_done), 32'd1);

        // Abort at count 100 with a colliding start
        new_scn();
        start = 1'b1; limit = 8'd211;
        step();
        start = 1'b0;
        for (int i = 0; i < 250 && m_cnt != 100; i++) step();
        chk("cl_at100", 32'(count), 32'd100);
        clr = 1'b1; start = 1'b1;
        step();
        clr = 1'b0; start = 1'b0;
        chk("cl_busy", 32'(busy), 32'd0);
        chk("cl_count", 32'(count), 32'd0);
        step();
        chk("cl_nostart", 32'(busy), 32'd0);
        chk("cl_noevt", 32'(n_wrap + n_done), 32'd0);

        // Restart with an oversize limit
        new_scn();
        start = 1'b1; limit = 8'd250;
        step();
        start = 1'b0;
        for (int i = 0; i < 218; i++) step();
        chk("ov_wrap_edge", 32'(wrap_edge), 32'd211);
        chk("ov_done_edge", 32'(done_edge), 32'd215);

        // limit=1 continuous, start while busy, then stop
        new_scn();
        start = 1'b1; mode = 1'b1; limit = 8'd1;
        step();
        start = 1'b0; mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start = (i == 2);
            limit = (i == 2) ? 8'd3 : 8'd1;
            step();
            chk("l1_count", 32'(count), 32'd0);
        end
        start = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("l1_nwrap", 32'(n_wrap), 32'd7);
        chk("l1_pass", 32'(pass_cnt), 32'd7);
        chk("l1_ndone", 32'(n_done), 32'd1);

        // Async reset during drain
        new_scn();
        start = 1'b1; limit = 8'd2;
        step();
        start = 1'b0;
        for (int i = 0; i < 10 && m_st != 2; i++) step();
        chk("ar_in_drain", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_pass", 32'(pass_cnt), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_wrap", 32'(wrap), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 10; i++) step();
        chk("ar_nodone", 32'(n_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/schedule_sequencer.md
Name: schedule_sequencer

Overview:
- Parametrised successor to the fixed-modulus global step counter that sequences the shared array_mult/array_div datapath in the inverse engine.
- Adds:
  - compile-time width, default modulus and drain length
  - runtime-programmable modulus
  - start/busy/done handshake
  - single-pass or continuous mode
  - graceful stop
  - pipeline drain after the final pass, so shared-unit results land before done.
- Lives in each top that owns shared arithmetic; drives the `count` field of the block interface.

Parameters:
- WIDTH, 8, width of count and limit.
- MAX, 211, default/maximum modulus; count runs 0..MAX-1.
- DRAIN, 4, en-qualified cycles waited after the final wrap before done; 0 allowed.
- PW, 4, width of pass counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global clock enable (stall); same signal fed to shared mult/div.
- clr  in  1  synchronous abort to IDLE; highest priority after rst_n.
- start  in  1  request a sequence; accepted only in IDLE.
- mode  in  1  sampled with start: 0 = single pass, 1 = continuous until stop.
- limit  in  WIDTH  sampled with start; runtime modulus; 0 or >MAX selects MAX.
- stop  in  1  in RUN: end continuous operation at the next wrap.
- count  out  WIDTH  current step index.
- pass_cnt  out  PW  completed passes since start, wraps modulo 2^PW.
- busy  out  1  high in RUN and DRAIN.
- last  out  1  combinational: state==RUN && count==lim-1.
- wrap  out  1  registered one-clk pulse after each count wrap.
- done  out  1  registered one-clk pulse on completion.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, count=0, pass_cnt=0, lim=MAX, stop_pend=0, drain_cnt=0.
  - busy=0, wrap=0, done=0.
- Register lim (WIDTH) latched on start; mode_r and stop_pend are internal flops.
- States:
  - IDLE:
    - count held 0.
    - start=1 (regardless of en) → RUN; on the same edge: latch lim and mode_r, pass_cnt=0, stop_pend=0.
  - RUN:
    - On an edge with en=1: count<lim-1 → count+1.
    - count==lim-1 → count=0, pass_cnt+1, wrap=1 next cycle.
      - If mode_r=0 or stop_pend or stop → DRAIN (or IDLE with done=1 when DRAIN=0).
      - Else stay in RUN.
    - stop=1 in RUN sets stop_pend (sticky, independent of en). The current pass always completes.
  - DRAIN:
    - drain_cnt increments on en edges.
    - On the edge where drain_cnt reaches DRAIN-1 → IDLE, done=1, busy=0, drain_cnt=0.
- en=0 freezes count, pass_cnt, drain_cnt and state transitions except IDLE→RUN on start.
- wrap and done are exactly one clk wide even if en drops.
- clr=1: next edge → IDLE, count=0, drain_cnt=0, stop_pend=0; no done and no wrap. pass_cnt is retained for debug.
  - clr and start in the same cycle: clr wins; start is dropped.
- start while busy is ignored; there is no queueing.
- lim=1: count stays 0, and every en edge in RUN is a wrap.
- busy is a registered copy of (state!=IDLE).
- Latency, single pass, en=1, start at edge 0, lim=211:
  - count=0..210 after edges 0..210.
  - Edge 211 wraps, with wrap high the following cycle.
  - done high after edge 211+DRAIN.
- Async reset mid-operation: immediate return to the reset values; no done.

Test Plan:
- Single pass, limit=0, DRAIN=4, en=1, start at edge 0:
  - count walks 0..210; last high at count=210.
  - wrap pulse after edge 211, pass_cnt=1.
  - done pulse after edge 215; busy low after edge 215.
- Continuous mode, limit=5, stop asserted at count=2 of pass 3:
  - 3 wraps (pass_cnt=3) with stop taking effect on the third wrap.
  - Drain, then exactly one done pulse; count=0.
- Stall, limit=10, en toggling 1,0 every cycle:
  - count advances only on en edges; 20 clks to wrap.
  - Drain spans 8 clks; wrap and done stay 1 clk wide.
- clr at count=100 (limit=211), start asserted in the same cycle as clr:
  - IDLE next cycle, count=0, busy=0.
  - No done or wrap; start ignored.
  - A new start one cycle later runs normally.
- limit=250 (>MAX) → modulus 211; limit=1 → wrap every en cycle; start during busy → no effect on count.
- rst_n low mid-DRAIN → outputs at reset values immediately (asynchronously, not waiting for clk); no done after release.
